// File: rtl/rect_copy_controller_pkg.sv
// Shared constants and type definitions for the per-frame rectangle-table copy engine.
// Debug and trace code can decode the FSM state through rc_state_e.
package rect_copy_controller_pkg;

    localparam int RECT_COUNT = 64;
    localparam int RECT_WORDS = 6;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 13;
    localparam int RECT_BASE  = 'h1000;

    // Word offsets within one rectangle record
    typedef enum logic [2:0] {
        RECT_X,
        RECT_Y,
        RECT_W,
        RECT_H,
        RECT_COLOR,
        RECT_FLAGS
    } rect_word_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rc_state_e;

endpackage

// File: rtl/rect_copy_controller.sv
// Copies RECT_COUNT*RECT_WORDS words from CPU data memory into the GPU rect buffer once per frame.
// A read issued in one cycle becomes a GPU write in the next, using mem_dout directly as write data.
module rect_copy_controller #(
    parameter int RECT_COUNT = rect_copy_controller_pkg::RECT_COUNT,
    parameter int RECT_WORDS = rect_copy_controller_pkg::RECT_WORDS,
    parameter int DATA_WIDTH = rect_copy_controller_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rect_copy_controller_pkg::ADDR_WIDTH,
    parameter int RECT_BASE  = rect_copy_controller_pkg::RECT_BASE,
    parameter int GPU_AW     = $clog2(RECT_COUNT * RECT_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  copy_start,
    input  logic                  copy,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  gpu_we,
    output logic [GPU_AW-1:0]     gpu_addr,
    output logic [DATA_WIDTH-1:0] gpu_din,
    output logic                  busy,
    output logic                  done
);
    import rect_copy_controller_pkg::*;

    localparam int TOTAL = RECT_COUNT * RECT_WORDS;
    localparam int IW    = GPU_AW + 1;
    localparam logic [IW-1:0]         LAST_IDX = IW'(TOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(RECT_BASE);

    rc_state_e         state_q, state_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic              wr_valid_q, wr_valid_d;
    logic [GPU_AW-1:0] wr_idx_q, wr_idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_idx_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            wr_valid_q <= wr_valid_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    // Dropping copy in any busy state abandons the frame: back to IDLE, no done pulse,
    // and the read still in flight never turns into a write.
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        wr_valid_d = 1'b0;
        wr_idx_d   = rd_idx_q[GPU_AW-1:0];
        mem_re     = 1'b0;
        mem_addr   = '0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (copy_start && copy) begin
                    state_d  = READ;
                    rd_idx_d = '0;
                end
            end
            READ: begin
                mem_re     = 1'b1;
                mem_addr   = BASE_A + ADDR_WIDTH'(rd_idx_q);
                wr_valid_d = copy;
                rd_idx_d   = rd_idx_q + 1'b1;
                if (!copy) begin
                    state_d = IDLE;
                end else if (rd_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = copy ? DONE : IDLE;
            end
            DONE: begin
                done    = copy;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gating with copy keeps the GPU buffer untouched once the copy window has closed.
    assign gpu_we   = wr_valid_q && copy;
    assign gpu_addr = gpu_we ? wr_idx_q : '0;
    assign gpu_din  = gpu_we ? mem_dout : '0;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rect_copy_controller.sv
// Directed plus randomized bench: a schedule-based reference model predicts every output per cycle
// relative to the start pulse, including abort and async-reset behaviour.
module tb_rect_copy_controller;

    localparam int RC   = 2;
    localparam int RW   = 3;
    localparam int T    = RC * RW;
    localparam int BASE = 'h10;
    localparam int AW   = 13;
    localparam int DW   = 16;
    localparam int GAW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          copy_start;
    logic          copy;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;
    logic          gpu_we;
    logic [GAW-1:0] gpu_addr;
    logic [DW-1:0] gpu_din;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] data [T];

    int n_asserts = 0;
    int n_fails   = 0;
    int n_writes;
    int exp_writes;

    rect_copy_controller #(
        .RECT_COUNT(RC),
        .RECT_WORDS(RW),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RECT_BASE (BASE),
        .GPU_AW    (GAW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .copy_start(copy_start),
        .copy      (copy),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .gpu_we    (gpu_we),
        .gpu_addr  (gpu_addr),
        .gpu_din   (gpu_din),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory
    always @(posedge clk) begin
        if (mem_re) mem_dout <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk(tag, {busy, mem_re, gpu_we, done, mem_addr, gpu_addr, gpu_din}, 64'd0);
    endtask

    task automatic load_data(input bit rnd);
        for (int i = 0; i < T; i++) begin
            data[i] = rnd ? DW'($urandom_range(0, 16'hFFFF)) : DW'(16'hA0 + i);
            mem[BASE + i] = data[i];
        end
    endtask

    // Caller raises copy_start (and copy) before calling; cycle k lies between edge k-1 and edge k.
    // abort_at = cycle in which copy is first low (0 = never); start2_at = cycle carrying an extra start.
    task automatic run_copy(input string name, input int ncyc, input int abort_at, input int start2_at);
        bit st_ok, cp, e_busy, e_re, e_we, e_done;
        n_writes   = 0;
        exp_writes = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            copy_start = (k == start2_at);
            if (abort_at != 0 && k >= abort_at) copy = 1'b0;
            @(negedge clk);
            st_ok  = (abort_at == 0) || (k <= abort_at);
            cp     = (abort_at == 0) || (k < abort_at);
            e_busy = st_ok && (k <= T + 2);
            e_re   = st_ok && (k <= T);
            e_we   = cp && (k >= 2) && (k <= T + 1);
            e_done = cp && (k == T + 2);
            chk($sformatf("%s c%0d busy", name, k), 64'(busy), 64'(e_busy));
            chk($sformatf("%s c%0d mem_re", name, k), 64'(mem_re), 64'(e_re));
            chk($sformatf("%s c%0d gpu_we", name, k), 64'(gpu_we), 64'(e_we));
            chk($sformatf("%s c%0d done", name, k), 64'(done), 64'(e_done));
            if (e_re) chk($sformatf("%s c%0d mem_addr", name, k), 64'(mem_addr), 64'(BASE + k - 1));
            if (e_we) begin
                chk($sformatf("%s c%0d gpu_addr", name, k), 64'(gpu_addr), 64'(k - 2));
                chk($sformatf("%s c%0d gpu_din", name, k), 64'(gpu_din), 64'(data[k-2]));
                exp_writes++;
            end
            if (gpu_we === 1'b1) n_writes++;
        end
        chk({name, " write count"}, 64'(n_writes), 64'(exp_writes));
    endtask

    initial begin
        int a;
        reset      = 1'b0;
        copy       = 1'b0;
        copy_start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        load_data(1'b0);

        // 1: reset release then idle
        repeat (3) @(negedge clk);
        check_idle("in reset");
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_idle("idle after reset");
        end

        // 2: basic copy
        @(negedge clk);
        copy = 1'b1;
        copy_start = 1'b1;
        run_copy("basic", T + 3, 0, 0);

        // 3: second start during active copy is ignored
        @(negedge clk);
        copy_start = 1'b1;
        run_copy("restart", T + 3, 0, 3);

        // 4: abort at cycle 4, then a clean copy
        @(negedge clk);
        copy_start = 1'b1;
        run_copy("abort4", T + 3, 4, 0);
        @(negedge clk);
        copy = 1'b1;
        copy_start = 1'b1;
        run_copy("post_abort", T + 3, 0, 0);

        // 5: async reset at cycle 3
        @(negedge clk);
        copy_start = 1'b1;
        @(posedge clk);
        #1 copy_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre-reset busy/we", 64'({busy, gpu_we}), 64'(2'b11));
        reset = 1'b0;
        #1;
        check_idle("async reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle("idle after mid-copy reset");
        end

        // 6: start with copy low is ignored, then back-to-back frames
        copy = 1'b0;
        @(negedge clk);
        copy_start = 1'b1;
        @(negedge clk);
        copy_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle("start with copy=0");
        end
        load_data(1'b1);
        @(negedge clk);
        copy = 1'b1;
        copy_start = 1'b1;
        run_copy("frame_a", T + 3, 0, T + 3);
        load_data(1'b1);
        run_copy("frame_b", T + 3, 0, 0);

        // Randomized data and abort points
        for (int r = 0; r < 6; r++) begin
            load_data(1'b1);
            a = (r % 2 == 0) ? int'($urandom_range(1, T + 2)) : 0;
            @(negedge clk);
            copy = 1'b1;
            copy_start = 1'b1;
            run_copy($sformatf("rand%0d_a%0d", r, a), T + 3, a, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
